aes_uart_sched: RTL and testbench
=================================

AES_UART_SCHED -- requirements
Module: aes_uart_sched

Interface
REQ-001 Parameter TIMEOUT, default 4000, is the maximum number of RUN cycles allowed before a transaction is aborted; its legal range is 1..65535.
REQ-002 Parameter CLR_CYCLES, default 15, is the number of cycles core_rst is held before each transaction; its legal range is 1..255.
REQ-003 The design SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 Ports SHALL be, in order:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request pending.
- req_ready  out  2  one-cycle accept pulse, one-hot.
- req_data  in  256  plaintext; requester i uses bits [128i+127:128i].
- req_key  in  256  key; requester i uses bits [128i+127:128i].
- rsp_valid  out  2  one-cycle completion pulse, one-hot.
- rsp_data  out  128  received data.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- busy  out  1  high in any state other than IDLE.
- core_rst  out  1  reset to the AES-UART core.
- core_en_tx  out  1  transmit enable to the core.
- core_en_rx  out  1  receive enable to the core.
- core_data_in  out  128  data to the core.
- core_key  out  128  key to the core.
- core_tx_done  in  1  transmit-done from the core.
- core_rx_done  in  1  receive-done from the core.
- core_data_out  in  128  received data from the core.

Function
REQ-005 The FSM SHALL have states IDLE, CLR, LOAD, RUN and RESP; all outputs SHALL be registered.
REQ-006 In IDLE with any req_valid set, the block SHALL grant one requester, pulse its req_ready for exactly that cycle, latch its data and key, and go to CLR.
REQ-007 Grant SHALL be round-robin:
- If one requester is valid, it is granted.
- If both are valid, the requester other than last_grant is granted.
- last_grant updates on every grant.
REQ-008 CLR SHALL hold core_rst=1 with en_tx=en_rx=0 for exactly CLR_CYCLES cycles, then go to LOAD.
REQ-009 LOAD SHALL last one cycle, with core_rst=0, core_data_in and core_key driving the latched values, and enables still 0.
REQ-010 RUN SHALL hold core_en_tx=core_en_rx=1 and increment a 16-bit cycle counter from 0.
REQ-011 In RUN, core_tx_done and core_rx_done SHALL each be captured into sticky flags, in either order or in the same cycle.
REQ-012 When both sticky flags are set, the block SHALL register core_data_out into rsp_data with rsp_err=0, drop the enables, and go to RESP.
REQ-013 When the counter equals TIMEOUT with both flags not yet set, the block SHALL set rsp_data=0 and rsp_err=1 and go to RESP.
REQ-014 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-015 RESP SHALL pulse rsp_valid for the granted requester for one cycle, then return to IDLE; there is no response backpressure.
REQ-016 Done pulses received outside RUN SHALL be ignored, and sticky flags and the counter SHALL clear on entry to CLR.
REQ-017 req_valid SHALL be sampled only in IDLE; requests withdrawn before grant have no effect.
REQ-018 core_data_in and core_key SHALL hold their value from LOAD through RESP.
REQ-019 rsp_data and rsp_err SHALL hold their value until the next RESP.

Reset
REQ-020 Reset SHALL force:
- state to IDLE.
- req_ready, rsp_valid, rsp_err, busy, core_en_tx and core_en_rx to 0.
- rsp_data, core_data_in and core_key to 0.
- core_rst to 1, with IDLE deasserting it on the next cycle.
- last_grant to 1, so requester 0 wins the first tie.
REQ-021 Reset asserted mid-transaction SHALL abort the transaction without issuing rsp_valid.

Structure
REQ-022 Package aes_uart_pkg SHALL hold the state enum, DATA_W=128 and KEY_W=128.
REQ-023 Grant logic SHALL be in sub-module rr_arb2, which is combinational plus the last_grant register.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Single request: requester 0 sends data 0x00112233445566778899AABBCCDDEEFF with key 0x0F...0F.
  - Required response: req_ready[0] pulses, then core_rst is high for 15 cycles, then one LOAD cycle, then RUN.
  - Core model returns the data after 100 cycles; rsp_valid=2'b01, rsp_err=0, rsp_data equals the sent data.
- Contention: both requesters valid in the same IDLE cycle after reset.
  - Required response: requester 0 is served first, then requester 1.
  - Both still valid again: requester 0 is served next, i.e. grants alternate.
- Done ordering: core_rx_done arrives before core_tx_done, and in a second run both arrive in the same cycle.
  - Required response: exactly one rsp_valid per transaction in both cases.
- Timeout: TIMEOUT=50 and the core model never asserts done.
  - Required response: after 50 RUN cycles, rsp_err=1 and rsp_data=0.
  - Completion arriving in the same cycle as the timeout yields rsp_err=0.
- Abort: reset asserted on the 10th RUN cycle.
  - Required response: no rsp_valid, enables 0 on the next cycle, and core_rst=1.
  - The next request completes normally.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES-UART transaction scheduler.
//   DATA_W / KEY_W : width of one plaintext block and one key.
//   state_e        : scheduler FSM states.
package aes_uart_pkg;

  localparam int DATA_W = 128;
  localparam int KEY_W  = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_RUN,
    ST_RESP
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   req        : per-requester request vector
//   en         : a grant is taken this cycle when en is high and any req is set
//   gnt        : one-hot grant (all zero when no request)
//   gnt_idx    : index of the granted requester
// The grant is purely combinational; only the last-granted index is stored.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_q;  // tie goes to whoever did not win last time
      default: gnt_idx = 1'b0;
    endcase

    gnt = 2'b00;
    if (|req) begin
      gnt = gnt_idx ? 2'b10 : 2'b01;
    end

    last_d = last_q;
    if (en && (|req)) begin
      last_d = gnt_idx;
    end
  end

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/aes_uart_sched.sv
// Scheduler that serialises two requesters onto one AES-UART core.
// Each transaction: grant (IDLE) -> hold core in reset (CLR) -> present
// data/key (LOAD) -> enable tx/rx until both done or timeout (RUN) ->
// one-cycle response pulse (RESP).
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   req_valid/req_ready : per-requester request and one-hot accept pulse
//   req_data/req_key    : requester i uses bits [128i+127:128i]
//   rsp_valid/rsp_data/rsp_err : one-hot completion pulse, data, timeout flag
//   busy                : high whenever the FSM is not in IDLE
//   core_*              : control/data towards and from the AES-UART core
// Every output comes straight from a flop.
module aes_uart_sched
  import aes_uart_pkg::*;
#(
  parameter int TIMEOUT    = 4000,
  parameter int CLR_CYCLES = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_data,
  input  logic [2*KEY_W-1:0]  req_key,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic                core_rst,
  output logic                core_en_tx,
  output logic                core_en_rx,
  output logic [DATA_W-1:0]   core_data_in,
  output logic [KEY_W-1:0]    core_key,
  input  logic                core_tx_done,
  input  logic                core_rx_done,
  input  logic [DATA_W-1:0]   core_data_out
);

  localparam logic [7:0]  CLR_LAST = 8'(CLR_CYCLES - 1);
  localparam logic [15:0] TO_VAL   = 16'(TIMEOUT);

  state_e              state_q, state_d;
  logic [7:0]          clr_cnt_q, clr_cnt_d;
  logic [15:0]         run_cnt_q, run_cnt_d;
  logic                tx_flag_q, tx_flag_d;
  logic                rx_flag_q, rx_flag_d;
  logic                gnt_idx_q, gnt_idx_d;
  logic [1:0]          req_ready_q, req_ready_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic                core_rst_q, core_rst_d;
  logic                core_en_q, core_en_d;
  logic [DATA_W-1:0]   core_data_in_q, core_data_in_d;
  logic [KEY_W-1:0]    core_key_q, core_key_d;

  logic [1:0]          arb_gnt;
  logic                arb_idx;
  logic [DATA_W-1:0]   req_data_a [2];
  logic [KEY_W-1:0]    req_key_a  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_split
    assign req_data_a[gi] = req_data[gi*DATA_W +: DATA_W];
    assign req_key_a[gi]  = req_key[gi*KEY_W +: KEY_W];
  end

  // Requests are only looked at (and last_grant only advances) in IDLE.
  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (state_q == ST_IDLE),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    run_cnt_d      = run_cnt_q;
    tx_flag_d      = tx_flag_q;
    rx_flag_d      = rx_flag_q;
    gnt_idx_d      = gnt_idx_q;
    req_ready_d    = 2'b00;
    rsp_valid_d    = 2'b00;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    core_rst_d     = core_rst_q;
    core_en_d      = core_en_q;
    core_data_in_d = core_data_in_q;
    core_key_d     = core_key_q;

    case (state_q)
      ST_IDLE: begin
        core_rst_d = 1'b0;
        core_en_d  = 1'b0;
        if (|req_valid) begin
          state_d        = ST_CLR;
          gnt_idx_d      = arb_idx;
          req_ready_d    = arb_gnt;
          core_data_in_d = req_data_a[arb_idx];
          core_key_d     = req_key_a[arb_idx];
          core_rst_d     = 1'b1;
          clr_cnt_d      = 8'd0;
          run_cnt_d      = 16'd0;
          tx_flag_d      = 1'b0;
          rx_flag_d      = 1'b0;
        end
      end

      ST_CLR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d    = ST_LOAD;
          core_rst_d = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + 8'd1;
        end
      end

      ST_LOAD: begin
        state_d   = ST_RUN;
        core_en_d = 1'b1;
        run_cnt_d = 16'd0;
      end

      ST_RUN: begin
        // Include this cycle's pulses so simultaneous or late done still counts.
        tx_flag_d = tx_flag_q | core_tx_done;
        rx_flag_d = rx_flag_q | core_rx_done;
        if (tx_flag_d && rx_flag_d) begin
          // Completion is tested first, so it beats a coincident timeout.
          state_d     = ST_RESP;
          core_en_d   = 1'b0;
          rsp_data_d  = core_data_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = gnt_idx_q ? 2'b10 : 2'b01;
        end else if (run_cnt_q == TO_VAL) begin
          state_d     = ST_RESP;
          core_en_d   = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = gnt_idx_q ? 2'b10 : 2'b01;
        end else begin
          run_cnt_d = run_cnt_q + 16'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      clr_cnt_q      <= 8'd0;
      run_cnt_q      <= 16'd0;
      tx_flag_q      <= 1'b0;
      rx_flag_q      <= 1'b0;
      gnt_idx_q      <= 1'b0;
      req_ready_q    <= 2'b00;
      rsp_valid_q    <= 2'b00;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      busy_q         <= 1'b0;
      core_rst_q     <= 1'b1;
      core_en_q      <= 1'b0;
      core_data_in_q <= '0;
      core_key_q     <= '0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      run_cnt_q      <= run_cnt_d;
      tx_flag_q      <= tx_flag_d;
      rx_flag_q      <= rx_flag_d;
      gnt_idx_q      <= gnt_idx_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      busy_q         <= busy_d;
      core_rst_q     <= core_rst_d;
      core_en_q      <= core_en_d;
      core_data_in_q <= core_data_in_d;
      core_key_q     <= core_key_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = busy_q;
  assign core_rst     = core_rst_q;
  assign core_en_tx   = core_en_q;
  assign core_en_rx   = core_en_q;
  assign core_data_in = core_data_in_q;
  assign core_key     = core_key_q;

endmodule

// File: tb/tb_aes_uart_sched.sv
// Directed bench for aes_uart_sched. Instance u_a uses default parameters;
// instance u_b uses TIMEOUT=50 for the timeout scenarios. sel picks which
// instance receives req_valid and whose outputs the scenario tasks observe.
module tb_aes_uart_sched;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sel = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [255:0] req_data = '0;
  logic [255:0] req_key = '0;
  logic         core_tx_done = 1'b0;
  logic         core_rx_done = 1'b0;
  logic [127:0] core_data_out = '0;

  logic [1:0]   rv_a, rv_b;
  logic [1:0]   rdy_a, rdy_b, vld_a, vld_b;
  logic [127:0] rd_a, rd_b, din_a, din_b, key_a, key_b;
  logic         err_a, err_b, busy_a, busy_b, crst_a, crst_b;
  logic         etx_a, etx_b, erx_a, erx_b;

  logic [1:0]   ready_o, rsp_valid_o;
  logic [127:0] rsp_data_o, din_o, key_o;
  logic         rsp_err_o, busy_o, rst_o, en_tx_o, en_rx_o;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] D0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] K0 = {16{8'h0F}};
  localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] K1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  assign rv_a = sel ? 2'b00 : req_valid;
  assign rv_b = sel ? req_valid : 2'b00;

  aes_uart_sched u_a (
    .clk(clk), .reset(reset), .req_valid(rv_a), .req_ready(rdy_a),
    .req_data(req_data), .req_key(req_key), .rsp_valid(vld_a),
    .rsp_data(rd_a), .rsp_err(err_a), .busy(busy_a), .core_rst(crst_a),
    .core_en_tx(etx_a), .core_en_rx(erx_a), .core_data_in(din_a),
    .core_key(key_a), .core_tx_done(core_tx_done),
    .core_rx_done(core_rx_done), .core_data_out(core_data_out)
  );

  aes_uart_sched #(.TIMEOUT(50), .CLR_CYCLES(15)) u_b (
    .clk(clk), .reset(reset), .req_valid(rv_b), .req_ready(rdy_b),
    .req_data(req_data), .req_key(req_key), .rsp_valid(vld_b),
    .rsp_data(rd_b), .rsp_err(err_b), .busy(busy_b), .core_rst(crst_b),
    .core_en_tx(etx_b), .core_en_rx(erx_b), .core_data_in(din_b),
    .core_key(key_b), .core_tx_done(core_tx_done),
    .core_rx_done(core_rx_done), .core_data_out(core_data_out)
  );

  assign ready_o     = sel ? rdy_b  : rdy_a;
  assign rsp_valid_o = sel ? vld_b  : vld_a;
  assign rsp_data_o  = sel ? rd_b   : rd_a;
  assign rsp_err_o   = sel ? err_b  : err_a;
  assign busy_o      = sel ? busy_b : busy_a;
  assign rst_o       = sel ? crst_b : crst_a;
  assign en_tx_o     = sel ? etx_b  : etx_a;
  assign en_rx_o     = sel ? erx_b  : erx_a;
  assign din_o       = sel ? din_b  : din_a;
  assign key_o       = sel ? key_b  : key_a;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b00;
    core_tx_done = 1'b0;
    core_rx_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Raise requests, wait for the accept pulse, then walk through CLR and
  // LOAD into the first RUN cycle. ok is set only if RUN is reached with the
  // enables low during LOAD.
  task automatic to_run(input logic [1:0] valid, output logic [1:0] gnt,
                        output int clr_len, output logic [127:0] ld_data,
                        output logic [127:0] ld_key, output bit ok);
    int n;
    ok = 1'b0; gnt = 2'b00; clr_len = 0; ld_data = '0; ld_key = '0;
    req_valid = valid;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready_o == 2'b00 && n < 40);
    if (ready_o == 2'b00) begin
      req_valid = 2'b00;
      return;
    end
    gnt = ready_o;
    req_valid = 2'b00;
    while (rst_o && clr_len < 300) begin
      clr_len++;
      @(negedge clk);
    end
    ld_data = din_o;
    ld_key  = key_o;
    if (en_tx_o || en_rx_o) return;
    @(negedge clk);
    ok = en_tx_o && en_rx_o;
  endtask

  // Core model for the RUN phase: pulse tx/rx done on the given RUN cycle
  // index (negative = never) and record every response pulse.
  task automatic finish_txn(input int tx_at, input int rx_at,
                            input logic [127:0] dout, input int limit,
                            output int n_rsp, output int rsp_j,
                            output logic [1:0] rv, output logic [127:0] rd,
                            output logic re);
    n_rsp = 0; rsp_j = -1; rv = 2'b00; rd = '0; re = 1'b0;
    core_data_out = dout;
    for (int j = 0; j < limit; j++) begin
      core_tx_done = (j == tx_at);
      core_rx_done = (j == rx_at);
      @(negedge clk);
      core_tx_done = 1'b0;
      core_rx_done = 1'b0;
      if (rsp_valid_o != 2'b00) begin
        n_rsp++;
        if (rsp_j < 0) begin
          rsp_j = j; rv = rsp_valid_o; rd = rsp_data_o; re = rsp_err_o;
        end
      end
      if (rsp_j >= 0 && j >= rsp_j + 3) break;
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rdy_a !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b want 00", rdy_a); end
    checks++; if (vld_a !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b want 00", vld_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", err_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    checks++; if (etx_a !== 1'b0 || erx_a !== 1'b0) begin errors++; $display("FAIL rst_en: got tx=%b rx=%b want 0 0", etx_a, erx_a); end
    checks++; if (rd_a !== '0 || din_a !== '0 || key_a !== '0) begin errors++; $display("FAIL rst_data: got rsp=%h din=%h key=%h want zeros", rd_a, din_a, key_a); end
    checks++; if (crst_a !== 1'b1) begin errors++; $display("FAIL rst_core_rst: got %b want 1", crst_a); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (crst_a !== 1'b0) begin errors++; $display("FAIL idle_core_rst: got %b want 0", crst_a); end
    $display("reset: core_rst=%b busy=%b after release", crst_a, busy_a);
  endtask

  task automatic test_single();
    logic [1:0] g, rv; int cl, nr, rj; logic [127:0] ld, lk, rd; logic re; bit ok;
    sel = 1'b0;
    do_reset();
    req_data = {D1, D0}; req_key = {K1, K0};
    to_run(2'b01, g, cl, ld, lk, ok);
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", g); end
    checks++; if (cl != 15) begin errors++; $display("FAIL single_clr_len: got %0d want 15", cl); end
    checks++; if (!ok) begin errors++; $display("FAIL single_load_run: got ok=%0d want 1", ok); end
    checks++; if (ld !== D0 || lk !== K0) begin errors++; $display("FAIL single_load_vals: got %h/%h want %h/%h", ld, lk, D0, K0); end
    finish_txn(100, 100, din_o, 200, nr, rj, rv, rd, re);
    checks++; if (nr != 1) begin errors++; $display("FAIL single_rsp_count: got %0d want 1", nr); end
    checks++; if (rv !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b want 01", rv); end
    checks++; if (re !== 1'b0) begin errors++; $display("FAIL single_rsp_err: got %b want 0", re); end
    checks++; if (rd !== D0) begin errors++; $display("FAIL single_rsp_data: got %h want %h", rd, D0); end
    checks++; if (rj != 100) begin errors++; $display("FAIL single_latency: got %0d want 100", rj); end
    checks++; if (busy_o !== 1'b0 || rsp_data_o !== D0) begin errors++; $display("FAIL single_idle_hold: got busy=%b data=%h want 0 %h", busy_o, rsp_data_o, D0); end
    $display("single: grant=%b clr=%0d rsp=%b err=%b data=%h", g, cl, rv, re, rd);
  endtask

  task automatic test_contention();
    logic [1:0] g, rv; int cl, nr, rj; logic [127:0] ld, lk, rd; logic re; bit ok;
    logic [1:0] want [3];
    logic [127:0] wdat [3];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
    wdat[0] = D0; wdat[1] = D1; wdat[2] = D0;
    sel = 1'b0;
    do_reset();
    req_data = {D1, D0}; req_key = {K1, K0};
    for (int t = 0; t < 3; t++) begin
      to_run(2'b11, g, cl, ld, lk, ok);
      checks++; if (g !== want[t]) begin errors++; $display("FAIL contention_grant%0d: got %b want %b", t, g, want[t]); end
      checks++; if (ld !== wdat[t]) begin errors++; $display("FAIL contention_load%0d: got %h want %h", t, ld, wdat[t]); end
      finish_txn(7, 7, ld ^ {4{32'hA5A5_5A5A}}, 40, nr, rj, rv, rd, re);
      checks++; if (rv !== want[t] || nr != 1) begin errors++; $display("FAIL contention_rsp%0d: got %b x%0d want %b x1", t, rv, nr, want[t]); end
      checks++; if (rd !== (wdat[t] ^ {4{32'hA5A5_5A5A}})) begin errors++; $display("FAIL contention_data%0d: got %h want %h", t, rd, wdat[t] ^ {4{32'hA5A5_5A5A}}); end
      $display("contention %0d: grant=%b rsp=%b data=%h", t, g, rv, rd);
    end
  endtask

  task automatic test_done_order();
    logic [1:0] g, rv; int cl, nr, rj; logic [127:0] ld, lk, rd; logic re; bit ok;
    int tx_at [2];
    int rx_at [2];
    tx_at[0] = 30; rx_at[0] = 20;
    tx_at[1] = 25; rx_at[1] = 25;
    sel = 1'b0;
    req_data = {D1, D0}; req_key = {K1, K0};
    for (int t = 0; t < 2; t++) begin
      to_run(2'b10, g, cl, ld, lk, ok);
      finish_txn(tx_at[t], rx_at[t], 128'h1234 + 128'(t), 80, nr, rj, rv, rd, re);
      checks++; if (nr != 1 || rv !== 2'b10) begin errors++; $display("FAIL order%0d_rsp: got %b x%0d want 10 x1", t, rv, nr); end
      checks++; if (rj != tx_at[t] || re !== 1'b0) begin errors++; $display("FAIL order%0d_when: got j=%0d err=%b want j=%0d err=0", t, rj, re, tx_at[t]); end
      checks++; if (rd !== 128'h1234 + 128'(t)) begin errors++; $display("FAIL order%0d_data: got %h want %h", t, rd, 128'h1234 + 128'(t)); end
      $display("done order %0d: tx@%0d rx@%0d rsp=%b at %0d", t, tx_at[t], rx_at[t], rv, rj);
    end
  endtask

  task automatic test_timeout();
    logic [1:0] g, rv; int cl, nr, rj; logic [127:0] ld, lk, rd; logic re; bit ok;
    int tx_at [3];
    int rx_at [3];
    logic werr [3];
    tx_at[0] = -1; rx_at[0] = -1; werr[0] = 1'b1;
    tx_at[1] = 10; rx_at[1] = -1; werr[1] = 1'b1;
    tx_at[2] = 50; rx_at[2] = 50; werr[2] = 1'b0;
    sel = 1'b1;
    do_reset();
    req_data = {D1, D0}; req_key = {K1, K0};
    for (int t = 0; t < 3; t++) begin
      to_run(2'b01, g, cl, ld, lk, ok);
      checks++; if (!ok || g !== 2'b01) begin errors++; $display("FAIL timeout%0d_start: got ok=%0d grant=%b want 1 01", t, ok, g); end
      finish_txn(tx_at[t], rx_at[t], 128'hFACE, 100, nr, rj, rv, rd, re);
      checks++; if (nr != 1 || rj != 50) begin errors++; $display("FAIL timeout%0d_when: got x%0d at %0d want x1 at 50", t, nr, rj); end
      checks++; if (re !== werr[t]) begin errors++; $display("FAIL timeout%0d_err: got %b want %b", t, re, werr[t]); end
      checks++; if (rd !== (werr[t] ? 128'h0 : 128'hFACE)) begin errors++; $display("FAIL timeout%0d_data: got %h want %h", t, rd, werr[t] ? 128'h0 : 128'hFACE); end
      $display("timeout %0d: rsp at %0d err=%b data=%h", t, rj, re, rd);
    end
    sel = 1'b0;
  endtask

  task automatic test_abort();
    logic [1:0] g, rv; int cl, nr, rj; logic [127:0] ld, lk, rd; logic re; bit ok;
    int stray;
    sel = 1'b0;
    req_data = {D1, D0}; req_key = {K1, K0};
    to_run(2'b01, g, cl, ld, lk, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_start: got ok=%0d want 1", ok); end
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (en_tx_o !== 1'b0 || en_rx_o !== 1'b0 || rst_o !== 1'b1) begin errors++; $display("FAIL abort_core: got tx=%b rx=%b rst=%b want 0 0 1", en_tx_o, en_rx_o, rst_o); end
    checks++; if (rsp_data_o !== '0 || din_o !== '0 || busy_o !== 1'b0) begin errors++; $display("FAIL abort_clear: got data=%h din=%h busy=%b want zeros", rsp_data_o, din_o, busy_o); end
    reset = 1'b0;
    stray = (rsp_valid_o != 2'b00) ? 1 : 0;
    for (int j = 0; j < 150; j++) begin
      core_tx_done = (j == 5); core_rx_done = (j == 5);
      @(negedge clk);
      core_tx_done = 1'b0; core_rx_done = 1'b0;
      if (rsp_valid_o != 2'b00) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL abort_no_rsp: got %0d pulses want 0", stray); end
    to_run(2'b10, g, cl, ld, lk, ok);
    finish_txn(12, 12, 128'hBEEF, 40, nr, rj, rv, rd, re);
    checks++; if (g !== 2'b10 || nr != 1 || rv !== 2'b10 || re !== 1'b0 || rd !== 128'hBEEF) begin errors++; $display("FAIL abort_next: got g=%b n=%0d rv=%b err=%b data=%h want 10 1 10 0 beef", g, nr, rv, re, rd); end
    $display("abort: stray=%0d next rsp=%b data=%h", stray, rv, rd);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_done_order();
    test_timeout();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
